// File: rtl/trap_controller.sv
// Trap sequencer: saves mepc/mcause on exceptions, reads mtvec/mepc for redirects,
// and runs the I-cache flush handshake for FENCE.I before a one-cycle redirect strobe.
module trap_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        trapped,
  input  logic [2:0]  trap_status,
  input  logic [31:0] pc,
  input  logic [31:0] csr_read_data,
  input  logic        ic_clean_done,
  output logic        csr_write_enable,
  output logic [11:0] csr_write_address,
  output logic [31:0] csr_write_data,
  output logic [11:0] csr_read_address,
  output logic        ic_clean,
  output logic        trap_stall,
  output logic        trap_done,
  output logic [31:0] trap_target
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CSR_AW    = 12;
  localparam int unsigned CAUSE_W   = 4;

  // Trap kind encodings shared with the exception-detection stage.
  localparam logic [2:0] TRAP_NONE       = 3'd0;
  localparam logic [2:0] TRAP_EBREAK     = 3'd1;
  localparam logic [2:0] TRAP_ECALL      = 3'd2;
  localparam logic [2:0] TRAP_MISALIGNED = 3'd3;
  localparam logic [2:0] TRAP_MRET       = 3'd4;
  localparam logic [2:0] TRAP_FENCEI     = 3'd5;

  localparam logic [CSR_AW-1:0] CSR_MTVEC  = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC   = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE = 12'h342;

  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK     = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL      = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE_MEPC,
    S_WRITE_MCAUSE,
    S_READ_MTVEC,
    S_READ_MEPC,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [XLEN-1:0]     target_q, target_d;

  logic                wr_en_c;
  logic [CSR_AW-1:0]   wr_addr_c;
  logic [XLEN-1:0]     wr_data_c;
  logic [CSR_AW-1:0]   rd_addr_c;
  logic                ic_clean_c;
  logic                stall_c;
  logic                done_c;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cause_d    = cause_q;
    target_d   = target_q;
    wr_en_c    = 1'b0;
    wr_addr_c  = '0;
    wr_data_c  = '0;
    rd_addr_c  = '0;
    ic_clean_c = 1'b0;
    stall_c    = 1'b0;
    done_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trapped) begin
          case (trap_status)
            TRAP_ECALL: begin
              pc_d    = pc;
              cause_d = CAUSE_ECALL;
              state_d = S_WRITE_MEPC;
              stall_c = 1'b1;
            end
            TRAP_EBREAK: begin
              pc_d    = pc;
              cause_d = CAUSE_EBREAK;
              state_d = S_WRITE_MEPC;
              stall_c = 1'b1;
            end
            TRAP_MISALIGNED: begin
              pc_d    = pc;
              cause_d = CAUSE_MISALIGNED;
              state_d = S_WRITE_MEPC;
              stall_c = 1'b1;
            end
            TRAP_MRET: begin
              state_d = S_READ_MEPC;
              stall_c = 1'b1;
            end
            TRAP_FENCEI: begin
              pc_d    = pc;
              state_d = S_FLUSH;
              stall_c = 1'b1;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WRITE_MEPC: begin
        wr_en_c   = 1'b1;
        wr_addr_c = CSR_MEPC;
        wr_data_c = pc_q;
        stall_c   = 1'b1;
        state_d   = S_WRITE_MCAUSE;
      end
      S_WRITE_MCAUSE: begin
        wr_en_c   = 1'b1;
        wr_addr_c = CSR_MCAUSE;
        wr_data_c = XLEN'(cause_q);
        stall_c   = 1'b1;
        state_d   = S_READ_MTVEC;
      end
      S_READ_MTVEC: begin
        // Direct mode only: mode bits of mtvec are dropped from the target.
        rd_addr_c = CSR_MTVEC;
        target_d  = {csr_read_data[XLEN-1:2], 2'b00};
        stall_c   = 1'b1;
        state_d   = S_DONE;
      end
      S_READ_MEPC: begin
        rd_addr_c = CSR_MEPC;
        target_d  = csr_read_data;
        stall_c   = 1'b1;
        state_d   = S_DONE;
      end
      S_FLUSH: begin
        ic_clean_c = 1'b1;
        stall_c    = 1'b1;
        if (ic_clean_done) begin
          target_d = pc_q + XLEN'(4);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  // Reset blanks every output in the same cycle, aborting any in-flight sequence.
  assign csr_write_enable  = ~reset & wr_en_c;
  assign csr_write_address = reset ? '0 : wr_addr_c;
  assign csr_write_data    = reset ? '0 : wr_data_c;
  assign csr_read_address  = reset ? '0 : rd_addr_c;
  assign ic_clean          = ~reset & ic_clean_c;
  assign trap_stall        = ~reset & stall_c;
  assign trap_done         = ~reset & done_c;
  assign trap_target       = reset ? '0 : target_q;

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: stimulus queues expected CSR writes and
// redirects with their cycle; a negedge monitor pops and compares every DUT event.
module tb_trap_controller;

  localparam logic [2:0] T_NONE = 3'd0, T_EBREAK = 3'd1, T_ECALL = 3'd2,
                         T_MISAL = 3'd3, T_MRET = 3'd4, T_FENCEI = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trapped = 1'b0;
  logic [2:0]  trap_status = 3'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] csr_read_data;
  logic        ic_clean_done = 1'b0;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic [11:0] csr_read_address;
  logic        ic_clean;
  logic        trap_stall;
  logic        trap_done;
  logic [31:0] trap_target;

  logic [31:0] mtvec_val = 32'h0000_0803;
  logic [31:0] mepc_val  = 32'h0000_0104;

  typedef struct {
    bit          is_done;
    logic [11:0] addr;
    logic [31:0] data;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  trap_controller dut (
    .clk(clk), .reset(reset), .trapped(trapped), .trap_status(trap_status), .pc(pc),
    .csr_read_data(csr_read_data), .ic_clean_done(ic_clean_done),
    .csr_write_enable(csr_write_enable), .csr_write_address(csr_write_address),
    .csr_write_data(csr_write_data), .csr_read_address(csr_read_address),
    .ic_clean(ic_clean), .trap_stall(trap_stall), .trap_done(trap_done),
    .trap_target(trap_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational CSR file read port.
  always_comb begin
    csr_read_data = 32'hDEAD_BEEF;
    if (csr_read_address == 12'h305) csr_read_data = mtvec_val;
    else if (csr_read_address == 12'h341) csr_read_data = mepc_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input int c, input string t);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.cyc = c; e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] tgt, input int c, input string t);
    exp_t e;
    e.is_done = 1'b1; e.addr = 12'h0; e.data = tgt; e.cyc = c; e.tag = t;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drain(input string t);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    chk({t, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_outputs(input string t);
    chk({t, "_stall"}, 32'(trap_stall), 32'd0);
    chk({t, "_we"}, 32'(csr_write_enable), 32'd0);
    chk({t, "_done"}, 32'(trap_done), 32'd0);
    chk({t, "_raddr"}, 32'(csr_read_address), 32'd0);
    chk({t, "_icc"}, 32'(ic_clean), 32'd0);
  endtask

  // Monitor: every write strobe or redirect strobe must match the queue head.
  always @(negedge clk) begin
    if (csr_write_enable || trap_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {csr_write_enable, trap_done, 30'(csr_write_address)}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.tag, "_kind"}, 32'(trap_done), 32'(e.is_done));
        chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
        if (e.is_done) begin
          chk({e.tag, "_target"}, trap_target, e.data);
        end else begin
          chk({e.tag, "_waddr"}, 32'(csr_write_address), 32'(e.addr));
          chk({e.tag, "_wdata"}, csr_write_data, e.data);
        end
      end
    end
  end

  initial begin
    int n;
    int cnt;

    // Reset with a trap and flush-done pending: everything must stay 0.
    trapped = 1'b1; trap_status = T_ECALL; pc = 32'h0000_0100; ic_clean_done = 1'b1;
    repeat (2) smp();
    idle_outputs("reset");
    chk("reset_target", trap_target, 32'd0);
    step();
    reset = 1'b0; trapped = 1'b0; ic_clean_done = 1'b0;
    smp();
    idle_outputs("post_reset");

    // ECALL
    step();
    trapped = 1'b1; trap_status = T_ECALL; pc = 32'h0000_0100; n = cyc;
    push_wr(12'h341, 32'h0000_0100, n + 1, "ecall_mepc");
    push_wr(12'h342, 32'd11, n + 2, "ecall_mcause");
    push_done(32'h0000_0800, n + 4, "ecall_done");
    smp();
    chk("ecall_stall0", 32'(trap_stall), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) trapped = 1'b0;
      smp();
      chk($sformatf("ecall_stall%0d", i), 32'(trap_stall), (i < 4) ? 32'd1 : 32'd0);
      if (i == 3) chk("ecall_raddr", 32'(csr_read_address), 32'h305);
    end
    drain("ecall");

    // MRET
    step();
    trapped = 1'b1; trap_status = T_MRET; n = cyc;
    push_done(32'h0000_0104, n + 2, "mret_done");
    smp();
    chk("mret_stall0", 32'(trap_stall), 32'd1);
    step();
    trapped = 1'b0;
    smp();
    chk("mret_raddr", 32'(csr_read_address), 32'h341);
    step();
    smp();
    chk("mret_stall2", 32'(trap_stall), 32'd0);
    drain("mret");

    // Flush-done outside FLUSH must be ignored.
    step();
    ic_clean_done = 1'b1;
    smp();
    idle_outputs("stray_icdone");
    step();
    ic_clean_done = 1'b0;
    drain("stray_icdone");

    // FENCE.I with PC wrap: three waiting cycles then completion.
    step();
    trapped = 1'b1; trap_status = T_FENCEI; pc = 32'hFFFF_FFFC; n = cyc;
    push_done(32'h0000_0000, n + 5, "fencei_done");
    cnt = 0;
    smp();
    chk("fencei_stall0", 32'(trap_stall), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) trapped = 1'b0;
      if (i == 4) ic_clean_done = 1'b1;
      if (i == 5) ic_clean_done = 1'b0;
      smp();
      if (ic_clean) cnt++;
    end
    chk("fencei_icclean_cycles", 32'(cnt), 32'd4);
    drain("fencei");

    // MISALIGNED held high: second sequence only after DONE.
    step();
    trapped = 1'b1; trap_status = T_MISAL; pc = 32'h0000_0200; n = cyc;
    push_wr(12'h341, 32'h0000_0200, n + 1, "mis1_mepc");
    push_wr(12'h342, 32'd0, n + 2, "mis1_mcause");
    push_done(32'h0000_0800, n + 4, "mis1_done");
    push_wr(12'h341, 32'h0000_0200, n + 6, "mis2_mepc");
    push_wr(12'h342, 32'd0, n + 7, "mis2_mcause");
    push_done(32'h0000_0800, n + 9, "mis2_done");
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 6) trapped = 1'b0;
      smp();
      if (i == 4) chk("mis_stall_done", 32'(trap_stall), 32'd0);
      if (i == 5) chk("mis_stall_reaccept", 32'(trap_stall), 32'd1);
    end
    drain("misaligned");

    // EBREAK aborted by reset in WRITE_MCAUSE.
    step();
    trapped = 1'b1; trap_status = T_EBREAK; pc = 32'h0000_0300; n = cyc;
    push_wr(12'h341, 32'h0000_0300, n + 1, "ebrk_mepc");
    step();
    trapped = 1'b0;
    step();
    reset = 1'b1;
    smp();
    idle_outputs("ebrk_rst");
    chk("ebrk_rst_target", trap_target, 32'd0);
    step();
    reset = 1'b0;
    smp();
    idle_outputs("ebrk_after");
    chk("ebrk_after_target", trap_target, 32'd0);
    repeat (4) step();
    drain("ebrk");

    // TRAP_NONE and unlisted encodings are ignored.
    for (int s = 0; s < 3; s++) begin
      logic [2:0] st;
      st = (s == 0) ? T_NONE : 3'(5 + s);
      step();
      trapped = 1'b1; trap_status = st;
      smp();
      idle_outputs($sformatf("ignore%0d", st));
      step();
      trapped = 1'b0;
      repeat (3) step();
    end
    drain("ignore");

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 The block SHALL provide these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- trapped  in  1  trap request from exception detection.
- trap_status  in  3  trap kind, encoded by the trap.vh macros TRAP_NONE/EBREAK/ECALL/MISALIGNED/MRET/FENCEI.
- pc  in  32  PC of the trapping instruction.
- csr_read_data  in  32  combinational CSR-file read data for csr_read_address.
- ic_clean_done  in  1  instruction-cache flush complete.
- csr_write_enable  out  1  CSR write strobe.
- csr_write_address  out  12  CSR write address.
- csr_write_data  out  32  CSR write data.
- csr_read_address  out  12  CSR read address.
- ic_clean  out  1  instruction-cache flush request.
- trap_stall  out  1  holds the pipeline while a trap is sequenced.
- trap_done  out  1  one-cycle redirect strobe.
- trap_target  out  32  redirect PC, valid while trap_done=1.

Function
REQ-002 The FSM SHALL have states IDLE, WRITE_MEPC, WRITE_MCAUSE, READ_MTVEC, READ_MEPC, FLUSH and DONE.
REQ-003 In IDLE with trapped=1 and trap_status in {ECALL, EBREAK, MISALIGNED}, the block SHALL latch pc and the cause, then go to WRITE_MEPC.
REQ-004 In IDLE with trapped=1 and trap_status=MRET, the block SHALL go to READ_MEPC.
REQ-005 In IDLE with trapped=1 and trap_status=FENCEI, the block SHALL latch pc and go to FLUSH.
REQ-006 In IDLE with trapped=0, TRAP_NONE, or an unlisted encoding, the block SHALL stay in IDLE with no side effects.
REQ-007 In WRITE_MEPC, the block SHALL drive csr_write_enable=1, csr_write_address=0x341 and csr_write_data=latched pc, then go to WRITE_MCAUSE.
REQ-008 In WRITE_MCAUSE, the block SHALL drive csr_write_enable=1 and csr_write_address=0x342, with csr_write_data = 11 for ECALL, 3 for EBREAK and 0 for MISALIGNED, then go to READ_MTVEC.
REQ-009 In READ_MTVEC, the block SHALL drive csr_read_address=0x305, register trap_target = {csr_read_data[31:2], 2'b00}, then go to DONE.
REQ-010 In READ_MEPC, the block SHALL drive csr_read_address=0x341, register trap_target = csr_read_data, then go to DONE.
REQ-011 In FLUSH, the block SHALL hold ic_clean=1 every cycle until ic_clean_done=1 is sampled.
- On that edge it SHALL register trap_target = latched pc + 4 (mod 2^32) and go to DONE.
- There is no timeout.
REQ-012 In DONE, the block SHALL assert trap_done=1 for exactly one cycle, then return to IDLE.
REQ-013 trap_stall SHALL be 1 in WRITE_MEPC, WRITE_MCAUSE, READ_MTVEC, READ_MEPC and FLUSH, and 0 in DONE.
REQ-014 In IDLE, trap_stall SHALL be combinationally 1 in the same cycle as an accepted trap request (REQ-003..005), else 0.
REQ-015 csr_write_enable SHALL be 0 in every state other than WRITE_MEPC and WRITE_MCAUSE.
- csr_write_address and csr_write_data SHALL be 0 when csr_write_enable=0.
REQ-016 csr_read_address SHALL be 0 outside READ_MTVEC and READ_MEPC.
REQ-017 trapped SHALL be ignored in every state except IDLE; a trap present in DONE is accepted only after the block returns to IDLE.
REQ-018 Latency from an accepted request to trap_done SHALL be:
- 4 cycles for ECALL, EBREAK and MISALIGNED.
- 2 cycles for MRET.
- k+2 cycles for FENCEI, where k is the number of FLUSH cycles with ic_clean_done=0.
REQ-019 ic_clean_done SHALL be ignored outside FLUSH.
REQ-020 trap_target SHALL hold its last registered value outside DONE.

Reset
REQ-021 When reset=1 at a clock edge, the block SHALL enter IDLE and clear the latched pc, latched cause and trap_target to 0.
REQ-022 While reset=1, every output SHALL be 0 regardless of trapped.
REQ-023 Reset asserted in any non-IDLE state SHALL abort the sequence with no further CSR writes, ic_clean or trap_done.

Verification
REQ-024 ECALL: pc=0x0000_0100, mtvec=0x0000_0803 -> mepc write 0x100 at N+1, mcause write 11 at N+2, trap_done=1 with trap_target=0x800 at N+4, trap_stall=1 from N to N+3.
REQ-025 MRET: mepc=0x0000_0104 -> no CSR writes, trap_done=1 with trap_target=0x104 at N+2.
REQ-026 FENCEI: pc=0xFFFF_FFFC, ic_clean_done raised 3 cycles after FLUSH entry -> ic_clean=1 for those 3 cycles plus the completion cycle, trap_done=1 with trap_target=0x0000_0000 (wrap-around).
REQ-027 MISALIGNED with trapped held high through the sequence -> exactly one mepc write, one mcause write (value 0) and one trap_done; a second sequence starts only after DONE.
REQ-028 EBREAK with reset asserted in WRITE_MCAUSE -> no mcause write, all outputs 0 next cycle, block back in IDLE.
REQ-029 trapped=1 with trap_status=TRAP_NONE, and with an unlisted encoding -> trap_stall, CSR outputs and trap_done stay 0.
